// File: rtl/axi_bridge_mp.sv
// Multi-port sram-like to AXI3 bridge: NPORT masters share one AXI master, AXI ID = port index.
// Latency: addr_ok is combinational in the accept cycle, AR/AW/W valid one cycle later; rvalid/bvalid -> data_ok in the same cycle.
// Backpressure: a port waits (no addr_ok) while its AR/write slot is busy, its counter is full, its direction differs, or its read hits the pending write.
module axi_bridge_mp #(
  parameter int NPORT   = 2,
  parameter int MAX_OUT = 4,
  parameter int ID_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NPORT-1:0]      req,
  input  logic [NPORT-1:0]      wr,
  input  logic [2*NPORT-1:0]    size,
  input  logic [32*NPORT-1:0]   addr,
  input  logic [4*NPORT-1:0]    wstrb,
  input  logic [32*NPORT-1:0]   wdata,
  output logic [32*NPORT-1:0]   rdata,
  output logic [NPORT-1:0]      addr_ok,
  output logic [NPORT-1:0]      data_ok,
  output logic [ID_W-1:0]       arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_W-1:0]       rid,
  input  logic [31:0]           rdata_axi,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ID_W-1:0]       awid,
  output logic [31:0]           awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ID_W-1:0]       wid,
  output logic [31:0]           wdata_axi,
  output logic [3:0]            wstrb_axi,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [ID_W-1:0]       bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int CW = 4;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);
  localparam logic [PW:0]   NP      = (PW+1)'(NPORT);

  logic [PW-1:0]   rr_ptr;
  logic [CW-1:0]   cnt [NPORT];
  logic [NPORT-1:0] dir;
  logic            wr_pend;
  logic [29:0]     wr_pend_addr;

  logic [NPORT-1:0] elig;
  logic [PW:0]     cand;
  logic [PW-1:0]   win;
  logic            win_vld;
  logic            win_wr;
  logic [1:0]      win_size;
  logic [31:0]     win_addr;
  logic [31:0]     win_wdata;
  logic [3:0]      win_wstrb;

  // Response status and strobes are not used; every access is a single beat.
  logic unused_resp;
  assign unused_resp = ^{rresp, rlast, bresp};

  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign arlock  = 2'b00;
  assign awlock  = 2'b00;
  assign arcache = 4'd0;
  assign awcache = 4'd0;
  assign arprot  = 3'd0;
  assign awprot  = 3'd0;
  assign wlast   = 1'b1;
  assign rready  = 1'b1;
  assign bready  = 1'b1;

  // Read data is broadcast to every port; only the port flagged by data_ok samples it.
  assign rdata = {NPORT{rdata_axi}};

  // Per-port eligibility: counter room, direction lock, free AR slot / single write slot, RAW hazard.
  always_comb begin
    elig = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (req[p] && (cnt[p] < MAX_CNT) && ((cnt[p] == '0) || (dir[p] == wr[p]))) begin
        if (wr[p])
          elig[p] = !wr_pend;
        else
          elig[p] = !arvalid && !(wr_pend && (wr_pend_addr == addr[32*p+2 +: 30]));
      end
    end
  end

  // Round-robin pick: first eligible port at or after rr_ptr, wrapping.
  always_comb begin
    cand    = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(i);
      if (cand >= NP)
        cand = cand - NP;
      if (!win_vld && elig[cand[PW-1:0]]) begin
        win_vld = 1'b1;
        win     = cand[PW-1:0];
      end
    end
  end

  // Mux the winning port's request fields and drive the accept/response strobes.
  always_comb begin
    win_wr    = 1'b0;
    win_size  = '0;
    win_addr  = '0;
    win_wdata = '0;
    win_wstrb = '0;
    addr_ok   = '0;
    data_ok   = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (win == PW'(p)) begin
        win_wr    = wr[p];
        win_size  = size[2*p +: 2];
        win_addr  = addr[32*p +: 32];
        win_wdata = wdata[32*p +: 32];
        win_wstrb = wstrb[4*p +: 4];
      end
      if (!reset) begin
        addr_ok[p] = win_vld && (win == PW'(p));
        // Responses only count for a port that actually has that kind of access in flight,
        // so stragglers from before a reset are silently dropped.
        data_ok[p] = (rvalid && (rid == ID_W'(p)) && (cnt[p] != '0) && !dir[p]) ||
                     (bvalid && (bid == ID_W'(p)) && (cnt[p] != '0) && dir[p] && wr_pend);
      end
    end
  end

  // Bookkeeping: counters, direction, RR pointer, write-pending tracking and AXI holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      dir          <= '0;
      wr_pend      <= 1'b0;
      wr_pend_addr <= '0;
      for (int p = 0; p < NPORT; p++)
        cnt[p] <= '0;
      arvalid   <= 1'b0;
      arid      <= '0;
      araddr    <= '0;
      arsize    <= '0;
      awvalid   <= 1'b0;
      awid      <= '0;
      awaddr    <= '0;
      awsize    <= '0;
      wvalid    <= 1'b0;
      wid       <= '0;
      wdata_axi <= '0;
      wstrb_axi <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++)
        cnt[p] <= cnt[p] + CW'(addr_ok[p]) - CW'(data_ok[p]);

      if (arvalid && arready) arvalid <= 1'b0;
      if (awvalid && awready) awvalid <= 1'b0;
      if (wvalid && wready)   wvalid  <= 1'b0;
      if (bvalid && ((data_ok & dir) != '0)) wr_pend <= 1'b0;

      if (win_vld) begin
        rr_ptr   <= (win == PW'(NPORT-1)) ? '0 : win + 1'b1;
        dir[win] <= win_wr;
        if (win_wr) begin
          awvalid      <= 1'b1;
          awid         <= ID_W'(win);
          awaddr       <= win_addr;
          awsize       <= {1'b0, win_size};
          wvalid       <= 1'b1;
          wid          <= ID_W'(win);
          wdata_axi    <= win_wdata;
          wstrb_axi    <= win_wstrb;
          wr_pend      <= 1'b1;
          wr_pend_addr <= win_addr[31:2];
        end else begin
          arvalid <= 1'b1;
          arid    <= ID_W'(win);
          araddr  <= win_addr;
          arsize  <= {1'b0, win_size};
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_bridge_mp.sv
// Directed bench for axi_bridge_mp with a per-port response scoreboard.
// Drives inputs 1 time unit after posedge, samples on negedge.
// Expected read data is queued per port when a response is driven and popped on data_ok.
module tb_axi_bridge_mp;

  localparam int NPORT = 2;
  localparam int ID_W  = 4;

  logic                clk;
  logic                reset;
  logic [NPORT-1:0]    req, wr;
  logic [2*NPORT-1:0]  size;
  logic [32*NPORT-1:0] addr, wdata;
  logic [4*NPORT-1:0]  wstrb;
  logic [32*NPORT-1:0] rdata;
  logic [NPORT-1:0]    addr_ok, data_ok;
  logic [ID_W-1:0]     arid, awid, wid, rid, bid;
  logic [31:0]         araddr, awaddr, rdata_axi, wdata_axi;
  logic [7:0]          arlen, awlen;
  logic [2:0]          arsize, awsize, arprot, awprot;
  logic [1:0]          arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]          arcache, awcache, wstrb_axi;
  logic                arvalid, arready, rlast, rvalid, rready;
  logic                awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int checks = 0;
  int errors = 0;
  int n_acc;
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [32:0] mon_e;
  logic        mon_have;
  logic [1:0]  rr_exp [8];

  axi_bridge_mp #(.NPORT(NPORT), .MAX_OUT(4), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata_axi(wdata_axi), .wstrb_axi(wstrb_axi), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    req[p]             = r;
    wr[p]              = w;
    addr[32*p +: 32]   = a;
    wdata[32*p +: 32]  = d;
    wstrb[4*p +: 4]    = 4'hF;
    size[2*p +: 2]     = 2'd2;
  endtask

  task automatic push_exp(input int p, input logic is_wr, input logic [31:0] d);
    if (p == 0) q0.push_back({is_wr, d});
    else        q1.push_back({is_wr, d});
  endtask

  task automatic r_resp(input int p, input logic [31:0] d);
    rvalid    = 1'b1;
    rid       = 4'(p);
    rdata_axi = d;
    push_exp(p, 1'b0, d);
  endtask

  // Scoreboard: every data_ok must match the oldest queued response for that port.
  always @(negedge clk) begin
    if (!reset) begin
      for (int p = 0; p < NPORT; p++) begin
        if (data_ok[p]) begin
          mon_have = (p == 0) ? (q0.size() != 0) : (q1.size() != 0);
          chk($sformatf("sb_data_ok_expected_p%0d", p), mon_have, 1'b1);
          if (mon_have) begin
            if (p == 0) mon_e = q0.pop_front();
            else        mon_e = q1.pop_front();
            if (!mon_e[32])
              chk($sformatf("sb_rdata_p%0d", p), rdata[32*p +: 32], mon_e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rr_exp = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    reset = 1'b1; req = '0; wr = '0; size = '0; addr = '0; wstrb = '0; wdata = '0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rid = '0; rdata_axi = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
    bid = '0; bresp = '0; bvalid = 1'b0;

    // Reset state and constant fields
    step(); step(); probe();
    chk("rst_valids", {arvalid, awvalid, wvalid}, 3'b000);
    chk("rst_addr_ok", addr_ok, 2'b00);
    chk("rst_data_ok", data_ok, 2'b00);
    chk("const_zero", {arlen, awlen, arlock, awlock, arcache, awcache, arprot, awprot}, 0);
    chk("const_ones", {arburst, awburst, wlast, rready, bready}, 7'b0101111);
    step(); reset = 1'b0;

    // Single read on port 0
    set_port(0, 1'b1, 1'b0, 32'hBFC00000, 32'h0);
    probe(); chk("t1_addr_ok", addr_ok, 2'b01);
    step(); req[0] = 1'b0; arready = 1'b1;
    probe();
    chk("t1_arvalid", arvalid, 1'b1);
    chk("t1_arid", arid, 4'd0);
    chk("t1_arsize", arsize, 3'd2);
    chk("t1_araddr", araddr, 32'hBFC00000);
    step(); probe(); chk("t1_arvalid_drop", arvalid, 1'b0);
    step(); r_resp(0, 32'h3C1D0001);
    probe(); chk("t1_data_ok", data_ok, 2'b01);
    step(); rvalid = 1'b0;

    // Round-robin with both ports reading continuously
    set_port(0, 1'b1, 1'b0, 32'h10000000, 32'h0);
    set_port(1, 1'b1, 1'b0, 32'h20000000, 32'h0);
    for (int i = 0; i < 8; i++) begin
      probe(); chk($sformatf("rr_cycle%0d", i), addr_ok, rr_exp[i]);
      step();
    end
    req = '0;
    for (int i = 0; i < 4; i++) begin
      r_resp(1 - (i % 2), 32'hA0000000 + 32'(i));
      probe(); chk($sformatf("rr_resp%0d", i), data_ok, (i % 2 == 0) ? 2'b10 : 2'b01);
      step();
    end
    rvalid = 1'b0;

    // Outstanding limit on port 1
    set_port(1, 1'b1, 1'b0, 32'h30000000, 32'h0);
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      probe(); if (addr_ok[1]) n_acc++;
      step();
    end
    chk("maxout_accepts", n_acc, 4);
    r_resp(1, 32'h5A5A0001);
    probe();
    chk("maxout_full_block", addr_ok, 2'b00);
    chk("maxout_resp", data_ok, 2'b10);
    step(); rvalid = 1'b0;
    probe(); chk("maxout_fifth", addr_ok, 2'b10);
    step(); req[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r_resp(1, 32'hC0DE0000 + 32'(i));
      probe(); chk($sformatf("maxout_drain%0d", i), data_ok, 2'b10);
      step();
    end
    rvalid = 1'b0;

    // RAW hazard and independent AW/W handshakes
    set_port(1, 1'b1, 1'b1, 32'h80001000, 32'h00001234);
    probe(); chk("raw_wr_accept", addr_ok, 2'b10);
    step(); req[1] = 1'b0;
    set_port(0, 1'b1, 1'b0, 32'h80001002, 32'h0);
    probe();
    chk("wr_aw_fields", {awid, awaddr, awsize}, {4'd1, 32'h80001000, 3'd2});
    chk("wr_w_fields", {wid, wdata_axi, wstrb_axi}, {4'd1, 32'h00001234, 4'hF});
    for (int i = 0; i < 3; i++) begin
      if (i > 0) probe();
      chk($sformatf("raw_block%0d", i), addr_ok, 2'b00);
      chk($sformatf("raw_valids%0d", i), {awvalid, wvalid}, 2'b11);
      step();
    end
    addr[31:0] = 32'h80001004;
    probe(); chk("raw_other_word", addr_ok, 2'b01);
    step(); addr[31:0] = 32'h80001002; wready = 1'b1;
    probe(); chk("wo_both_valid", {awvalid, wvalid, addr_ok}, 4'b1100);
    step(); wready = 1'b0;
    probe(); chk("wo_w_dropped", {awvalid, wvalid, addr_ok}, 4'b1000);
    step();
    probe(); chk("wo_aw_holds", {awvalid, wvalid}, 2'b10);
    step(); awready = 1'b1;
    probe(); chk("wo_no_early_b", {awvalid, data_ok}, 3'b100);
    step(); awready = 1'b0;
    probe(); chk("wo_aw_dropped", {awvalid, data_ok, addr_ok}, 5'b00000);
    step();
    bvalid = 1'b1; bid = 4'd1; push_exp(1, 1'b1, 32'h0);
    r_resp(0, 32'hDEADBEEF);
    probe();
    chk("rb_same_cycle", data_ok, 2'b11);
    chk("raw_block_at_b", addr_ok, 2'b00);
    step(); bvalid = 1'b0; rvalid = 1'b0;
    probe(); chk("raw_release", addr_ok, 2'b01);
    step(); req[0] = 1'b0;
    r_resp(0, 32'h0BADF00D);
    probe(); chk("raw_read_done", data_ok, 2'b01);
    step(); rvalid = 1'b0;

    // Reset with two reads outstanding on port 0
    set_port(0, 1'b1, 1'b0, 32'h40000000, 32'h0);
    probe(); chk("rst_pre_acc0", addr_ok, 2'b01);
    step(); probe(); chk("rst_pre_gap", addr_ok, 2'b00);
    step(); probe(); chk("rst_pre_acc1", addr_ok, 2'b01);
    step(); arready = 1'b0; reset = 1'b1;
    probe(); chk("rst_mid_outputs", {addr_ok, data_ok}, 4'b0000);
    step(); reset = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rdata_axi = 32'hFFFF0000;
    probe();
    chk("rst_arvalid_clear", arvalid, 1'b0);
    chk("rst_first_accept", addr_ok, 2'b01);
    chk("rst_stale_dropped", data_ok, 2'b00);
    step(); rvalid = 1'b0; arready = 1'b1;
    n_acc = 1;
    for (int i = 0; i < 10; i++) begin
      probe(); if (addr_ok[0]) n_acc++;
      step();
    end
    chk("rst_cnt_cleared", n_acc, 4);
    req[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r_resp(0, 32'h77770000 + 32'(i));
      probe(); chk($sformatf("rst_drain%0d", i), data_ok, 2'b01);
      step();
    end
    rvalid = 1'b0;

    step(); step();
    chk("sb_q0_empty", q0.size(), 0);
    chk("sb_q1_empty", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
